pixel_write_arbiter: RTL and testbench

- Sits between the pixel-drawing objects (obstacle renderer = port A, player renderer = port B) and vga_adapter.
- Replaces the combinational obstacle-over-player mux, which silently loses player pixels when both write in the same cycle.
- Each port has a small FIFO. An arbiter drains both FIFOs, one pixel per cycle, into a single registered write stream.
- Port A has priority. Port B gets anti-starvation grants so it is never locked out.

---
 rtl/pixel_write_arbiter_if.sv | 39 +++
 rtl/pixel_write_arbiter.sv | 125 ++++++++++++
 tb/tb_pixel_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_arbiter_if.sv
// Pixel bus between the two renderers, the arbiter and vga_adapter.
// The master side drives pixels in; the slave side is the arbiter.
interface pixel_write_arbiter_if #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9
);
    logic [nX-1:0]          a_x;
    logic [nY-1:0]          a_y;
    logic [COLOR_DEPTH-1:0] a_color;
    logic                   a_write;
    logic                   a_ready;

    logic [nX-1:0]          b_x;
    logic [nY-1:0]          b_y;
    logic [COLOR_DEPTH-1:0] b_color;
    logic                   b_write;
    logic                   b_ready;

    logic [nX-1:0]          out_x;
    logic [nY-1:0]          out_y;
    logic [COLOR_DEPTH-1:0] out_color;
    logic                   out_write;
    logic [1:0]             overflow;

    modport master (
        output a_x, a_y, a_color, a_write,
        output b_x, b_y, b_color, b_write,
        input  a_ready, b_ready,
        input  out_x, out_y, out_color, out_write, overflow
    );

    modport slave (
        input  a_x, a_y, a_color, a_write,
        input  b_x, b_y, b_color, b_write,
        output a_ready, b_ready,
        output out_x, out_y, out_color, out_write, overflow
    );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Two-port pixel write arbiter: per-port FIFOs drained one pixel per cycle into a
// registered write stream, port A preferred, port B forced after MAX_WAIT A grants.
module pixel_write_arbiter #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int DEPTH       = 4,
    parameter int MAX_WAIT    = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  flush,
    pixel_write_arbiter_if.slave  bus
);
    localparam int W  = nX + nY + COLOR_DEPTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [1:0][W-1:0] din;
    logic [1:0]        wr;
    logic [1:0][W-1:0] head;
    logic [1:0]        non_empty;
    logic [1:0]        full;
    logic [1:0]        push_ok;
    logic [1:0]        drop;
    logic [1:0]        grant;

    logic [7:0]             wait_reg;
    logic                   force_b;
    logic [nX-1:0]          out_x_reg;
    logic [nY-1:0]          out_y_reg;
    logic [COLOR_DEPTH-1:0] out_color_reg;
    logic                   out_write_reg;
    logic [1:0]             overflow_reg;
    logic [W-1:0]           sel_word;

    assign din[0] = {bus.a_x, bus.a_y, bus.a_color};
    assign din[1] = {bus.b_x, bus.b_y, bus.b_color};
    assign wr[0]  = bus.a_write;
    assign wr[1]  = bus.b_write;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [W-1:0]  mem [DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;

            assign non_empty[gi] = (count_reg != '0);
            assign full[gi]      = (count_reg == CW'(DEPTH));
            // A full FIFO still accepts a push when its head leaves at the same edge.
            assign push_ok[gi]   = wr[gi] && !flush && (!full[gi] || grant[gi]);
            assign drop[gi]      = wr[gi] && !flush && !push_ok[gi];
            assign head[gi]      = mem[rd_ptr_reg];

            always_ff @(posedge Clock) begin
                if (push_ok[gi]) begin
                    mem[wr_ptr_reg] <= din[gi];
                end
            end

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (grant[gi])   rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + CW'(push_ok[gi]) - CW'(grant[gi]);
                end
            end
        end
    endgenerate

    // Grants are suppressed during flush so nothing is popped or emitted.
    always_comb begin
        force_b  = non_empty[1] && (wait_reg == 8'(MAX_WAIT));
        grant[0] = !flush && non_empty[0] && !force_b;
        grant[1] = !flush && non_empty[1] && !grant[0];
        sel_word = grant[1] ? head[1] : head[0];
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_reg <= '0;
        end else if (flush || grant[1] || !non_empty[1]) begin
            wait_reg <= '0;
        end else if (grant[0] && (wait_reg != 8'(MAX_WAIT))) begin
            wait_reg <= wait_reg + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_color_reg <= '0;
            out_write_reg <= 1'b0;
            overflow_reg  <= 2'b00;
        end else if (flush) begin
            out_write_reg <= 1'b0;
            overflow_reg  <= 2'b00;
        end else begin
            out_write_reg <= |grant;
            overflow_reg  <= overflow_reg | drop;
            if (|grant) begin
                {out_x_reg, out_y_reg, out_color_reg} <= sel_word;
            end
        end
    end

    assign bus.a_ready   = !full[0];
    assign bus.b_ready   = !full[1];
    assign bus.out_x     = out_x_reg;
    assign bus.out_y     = out_y_reg;
    assign bus.out_color = out_color_reg;
    assign bus.out_write = out_write_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomised and directed bench for pixel_write_arbiter against a queue-based
// model of the two FIFOs and the priority / anti-starvation rules.
module tb_pixel_write_arbiter;
    localparam int nX          = 10;
    localparam int nY          = 9;
    localparam int COLOR_DEPTH = 9;
    localparam int DEPTH       = 4;
    localparam int MAX_WAIT    = 8;

    typedef logic [nX+nY+COLOR_DEPTH-1:0] word_t;

    logic Clock;
    logic Resetn;
    logic flush;

    pixel_write_arbiter_if #(.nX(nX), .nY(nY), .COLOR_DEPTH(COLOR_DEPTH)) bus ();

    pixel_write_arbiter #(
        .nX(nX), .nY(nY), .COLOR_DEPTH(COLOR_DEPTH), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .flush(flush),
        .bus(bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 0;

    // Model state: expected contents after the next rising edge.
    word_t qa[$];
    word_t qb[$];
    int    m_wait;
    logic [1:0] m_ovf;
    logic  exp_write;
    logic [nX-1:0] exp_x;
    logic [nY-1:0] exp_y;
    logic [COLOR_DEPTH-1:0] exp_c;
    int    out_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_wait    = 0;
        m_ovf     = 2'b00;
        exp_write = 1'b0;
        exp_x     = '0;
        exp_y     = '0;
        exp_c     = '0;
    endtask

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_step();
        bit a_ne, b_ne, ga, gb;
        word_t w;
        if (!Resetn) begin
            model_reset();
            return;
        end
        if (flush) begin
            qa.delete();
            qb.delete();
            m_wait    = 0;
            m_ovf     = 2'b00;
            exp_write = 1'b0;
            return;
        end
        a_ne = (qa.size() > 0);
        b_ne = (qb.size() > 0);
        ga   = a_ne && !(b_ne && m_wait == MAX_WAIT);
        gb   = b_ne && !ga;
        exp_write = ga || gb;
        if (ga) begin
            w = qa.pop_front();
            {exp_x, exp_y, exp_c} = w;
        end else if (gb) begin
            w = qb.pop_front();
            {exp_x, exp_y, exp_c} = w;
        end
        if (gb || !b_ne) m_wait = 0;
        else if (ga && m_wait < MAX_WAIT) m_wait++;
        if (bus.a_write) begin
            if (qa.size() < DEPTH) qa.push_back({bus.a_x, bus.a_y, bus.a_color});
            else m_ovf[0] = 1'b1;
        end
        if (bus.b_write) begin
            if (qb.size() < DEPTH) qb.push_back({bus.b_x, bus.b_y, bus.b_color});
            else m_ovf[1] = 1'b1;
        end
    endtask

    task automatic cycle(input bit aw, input int ax, input int ay, input int ac,
                         input bit bw, input int bx, input int by, input int bc,
                         input bit fl);
        @(negedge Clock);
        bus.a_write = aw;
        bus.a_x     = nX'(ax);
        bus.a_y     = nY'(ay);
        bus.a_color = COLOR_DEPTH'(ac);
        bus.b_write = bw;
        bus.b_x     = nX'(bx);
        bus.b_y     = nY'(by);
        bus.b_color = COLOR_DEPTH'(bc);
        flush       = fl;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model.
    always @(posedge Clock) begin
        #1;
        if (check_en) begin
            check("out_write", 32'(bus.out_write), 32'(exp_write));
            check("out_x", 32'(bus.out_x), 32'(exp_x));
            check("out_y", 32'(bus.out_y), 32'(exp_y));
            check("out_color", 32'(bus.out_color), 32'(exp_c));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            check("a_ready", 32'(bus.a_ready), 32'(qa.size() != DEPTH));
            check("b_ready", 32'(bus.b_ready), 32'(qb.size() != DEPTH));
            if (bus.out_write) out_log.push_back(int'(bus.out_x));
        end
    end

    initial begin
        int bseq[$];
        int pa, pb;
        Resetn = 1'b0;
        flush  = 1'b0;
        bus.a_write = 0; bus.a_x = '0; bus.a_y = '0; bus.a_color = '0;
        bus.b_write = 0; bus.b_x = '0; bus.b_y = '0; bus.b_color = '0;
        model_reset();
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        check_en = 1;
        #1;
        check("rst_out_write", 32'(bus.out_write), 0);
        check("rst_out_x", 32'(bus.out_x), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_a_ready", 32'(bus.a_ready), 1);
        check("rst_b_ready", 32'(bus.b_ready), 1);

        // Single pixel: two-edge latency, one pulse.
        out_log.delete();
        cycle(1, 100, 50, 'h1FF, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("t1_not_yet", 32'(bus.out_write), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t1_write", 32'(bus.out_write), 1);
        check("t1_x", 32'(bus.out_x), 100);
        check("t1_y", 32'(bus.out_y), 50);
        check("t1_color", 32'(bus.out_color), 'h1FF);
        check("t1_overflow", 32'(bus.overflow), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("t1_one_pulse", 32'(bus.out_write), 0);

        // Simultaneous A and B: A then B on consecutive cycles.
        out_log.delete();
        cycle(1, 10, 1, 1, 1, 20, 2, 2, 0);
        idle(5);
        check("t2_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t2_first", out_log[0], 10);
            check("t2_second", out_log[1], 20);
        end
        check("t2_overflow", 32'(bus.overflow), 0);

        // Anti-starvation: B appears as 9th pixel.
        out_log.delete();
        for (int i = 0; i < 20; i++) cycle(1, i, 3, 3, i == 0, 500, 4, 4, 0);
        idle(10);
        check("t3_count", out_log.size(), 21);
        if (out_log.size() == 21) begin
            for (int k = 0; k < 8; k++) check("t3_a_before", out_log[k], k);
            check("t3_b_ninth", out_log[8], 500);
            check("t3_a_after", out_log[9], 8);
            check("t3_a_last", out_log[20], 19);
        end

        // B overflow while A keeps A priority.
        out_log.delete();
        for (int i = 0; i < 30; i++) begin
            cycle(1, i, 5, 5, i < 6, 600 + i, 6, 6, 0);
            if (i == 4) #1 check("t4_b_ready_full", 32'(bus.b_ready), 0);
        end
        idle(12);
        check("t4_overflow", 32'(bus.overflow), 2);
        bseq.delete();
        foreach (out_log[k]) if (out_log[k] >= 600) bseq.push_back(out_log[k]);
        check("t4_b_count", bseq.size(), 4);
        if (bseq.size() == 4)
            for (int k = 0; k < 4; k++) check("t4_b_order", bseq[k], 600 + k);

        // Flush with queued pixels.
        cycle(1, 31, 0, 0, 1, 41, 0, 0, 0);
        cycle(1, 32, 0, 0, 1, 42, 0, 0, 0);
        cycle(1, 33, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 34, 0, 0, 1, 44, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t5_write", 32'(bus.out_write), 0);
        check("t5_overflow", 32'(bus.overflow), 0);
        check("t5_a_ready", 32'(bus.a_ready), 1);
        check("t5_b_ready", 32'(bus.b_ready), 1);
        out_log.delete();
        idle(3);
        check("t5_silent", out_log.size(), 0);
        cycle(1, 77, 7, 7, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("t5_not_yet", 32'(bus.out_write), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t5_write_after", 32'(bus.out_write), 1);
        check("t5_x_after", 32'(bus.out_x), 77);

        // Randomised traffic with occasional flush.
        for (int blk = 0; blk < 20; blk++) begin
            pa = $urandom_range(0, 100);
            pb = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++)
                cycle($urandom_range(0, 99) < pa, $urandom, $urandom, $urandom,
                      $urandom_range(0, 99) < pb, $urandom, $urandom, $urandom,
                      $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) cycle(1, 200 + i, 1, 1, 1, 300 + i, 2, 2, 0);
        #2;
        Resetn = 1'b0;
        model_reset();
        out_log.delete();
        #1;
        check("t6_write", 32'(bus.out_write), 0);
        check("t6_x", 32'(bus.out_x), 0);
        check("t6_color", 32'(bus.out_color), 0);
        check("t6_overflow", 32'(bus.overflow), 0);
        idle(2);
        Resetn = 1'b1;
        idle(4);
        check("t6_no_write", out_log.size(), 0);
        check("t6_a_ready", 32'(bus.a_ready), 1);
        check("t6_b_ready", 32'(bus.b_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
